// File: rtl/iob_clint_arb_pkg.sv
// Shared definitions for the CLINT arbiter: FSM state encoding and the CLINT
// register map used by the arbiter and by CLINT-facing benches.
package iob_clint_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP
  } arb_state_t;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_BASE    = 16'hbff8;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_picker.sv
// Combinational round-robin search: first set request strictly after ptr,
// wrapping to the lowest set request when none lies above it.
module iob_rr_picker
  import iob_clint_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [N_REQ-1:0] above;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] pool;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_above
      assign above[gi] = (gi > int'(ptr));
    end
  endgenerate

  assign masked = req & above;
  assign pool   = (|masked) ? masked : req;
  // Isolate the lowest set bit of the candidate pool.
  assign grant  = pool & (~pool + N_REQ'(1));
  assign any    = |req;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/iob_clint_arbiter.sv
// Round-robin arbiter sharing the CLINT native slave port among N_REQ masters,
// one transaction in flight. Define IOB_CLINT_ARB_TIMEOUT_EN for the WAIT timeout.
module iob_clint_arbiter
  import iob_clint_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_address,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic [N_REQ*DATA_W/8-1:0] req_wstrb,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      s_valid,
  output logic [ADDR_W-1:0]         s_address,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [DATA_W/8-1:0]       s_wstrb,
  input  logic [DATA_W-1:0]         s_rdata,
  input  logic                      s_ready,
  output logic                      timeout_err
);

  localparam int IDX_W  = idx_w(N_REQ);
  localparam int STRB_W = DATA_W / 8;

  arb_state_t          state_reg, state_next;
  logic [IDX_W-1:0]    ptr_reg, pick_idx;
  logic [N_REQ-1:0]    grant_oh_reg, pick_oh;
  logic                pick_any;
  logic [ADDR_W-1:0]   addr_reg, sel_addr;
  logic [DATA_W-1:0]   wdata_reg, sel_wdata;
  logic [STRB_W-1:0]   wstrb_reg, sel_wstrb;
  logic [DATA_W-1:0]   rdata_reg;
  logic                abort;

  iob_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (pick_oh),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr  = sel_addr  | req_address[i*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = sel_wstrb | req_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Arbitration happens only in IDLE, so a completing master is never re-granted in RESP.
  always_comb begin
    state_next = state_reg;
    s_valid    = 1'b0;
    req_ready  = '0;
    case (state_reg)
      S_IDLE:  if (pick_any) state_next = S_ISSUE;
      S_ISSUE: begin
        s_valid    = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT:  if (s_ready || abort) state_next = S_RESP;
      S_RESP:  begin
        req_ready  = grant_oh_reg;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg      <= IDX_W'(N_REQ - 1);
      grant_oh_reg <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      rdata_reg    <= '0;
    end else begin
      if (state_reg == S_IDLE && pick_any) begin
        ptr_reg      <= pick_idx;
        grant_oh_reg <= pick_oh;
        addr_reg     <= sel_addr;
        wdata_reg    <= sel_wdata;
        wstrb_reg    <= sel_wstrb;
      end
      if (state_reg == S_WAIT) begin
        if (s_ready)    rdata_reg <= s_rdata;
        else if (abort) rdata_reg <= '1;
      end
    end
  end

  assign s_address = addr_reg;
  assign s_wdata   = wdata_reg;
  assign s_wstrb   = s_valid ? wstrb_reg : '0;
  assign req_rdata = rdata_reg;

`ifdef IOB_CLINT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             err_reg;

  // Abort on the TIMEOUT-th consecutive WAIT cycle without s_ready.
  assign abort = (state_reg == S_WAIT) && !s_ready &&
                 (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg == S_WAIT && !s_ready) wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      else                                 wait_cnt_reg <= '0;
      if (abort) err_reg <= 1'b1;
    end
  end

  assign timeout_err = err_reg;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign abort          = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_iob_clint_arbiter.sv
// Bench for iob_clint_arbiter: timeline-based reference model checked every cycle,
// a small CLINT memory model as slave, directed cases and randomized traffic.
module tb_iob_clint_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_address = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N*SW-1:0]   req_wstrb = '0;
  logic [DW-1:0]     req_rdata;
  logic [N-1:0]      req_ready;
  logic              s_valid;
  logic [AW-1:0]     s_address;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic [DW-1:0]     s_rdata;
  logic              s_ready;
  logic              timeout_err;

  iob_clint_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_address(req_address), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_rdata(req_rdata), .req_ready(req_ready),
    .s_valid(s_valid), .s_address(s_address), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; int at; logic [31:0] rdata; } done_t;
  done_t rdy_log[$];
  int    sv_cyc[$];

  logic [31:0] mem [int];
  logic [15:0] slave_last_addr = '0;
  bit          slave_fixed = 1'b1;
  bit          slave_stuck = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CLINT stand-in: ready 1 cycle after valid (or a few more in random mode).
  initial begin : slave_proc
    int delay;
    bit pending;
    logic [15:0] a;
    logic [31:0] w, cur;
    logic [3:0]  st;
    s_ready = 1'b0; s_rdata = '0; pending = 0; delay = 0; a = '0; w = '0; st = '0;
    forever begin
      @(negedge clk);
      if (rst) pending = 0;
      else if (s_valid) begin
        pending = 1; a = s_address; w = s_wdata; st = s_wstrb; slave_last_addr = s_address;
        delay = (slave_fixed || $urandom_range(0, 3) != 0) ? 1 : int'($urandom_range(2, 5));
      end
      @(posedge clk); #1;
      s_ready = 1'b0;
      s_rdata = $urandom;
      if (pending && !slave_stuck) begin
        delay--;
        if (delay == 0) begin
          cur = mem.exists(int'(a)) ? mem[int'(a)] : 32'h0;
          s_ready = 1'b1;
          s_rdata = cur;
          for (int b = 0; b < 4; b++) if (st[b]) cur[b*8 +: 8] = w[b*8 +: 8];
          mem[int'(a)] = cur;
          pending = 0;
        end
      end
    end
  end

  // Reference model: a transaction timeline (grant, issue, response, completion cycles).
  int          m_ptr, m_win, m_issue, m_ready, m_free;
  bit          m_wait, m_err;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_strb;

  always @(negedge clk) begin : cmp
    logic         exp_sv;
    logic [N-1:0] exp_rr;
    int           idx;
    if (rst) begin
      m_ptr = N - 1; m_issue = -10; m_ready = -10; m_free = 0; m_wait = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_strb = '0; m_win = 0; m_rdata = '0;
      chk("rst_s_valid", s_valid, 0);
      chk("rst_s_address", s_address, 0);
      chk("rst_s_wdata", s_wdata, 0);
      chk("rst_s_wstrb", s_wstrb, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_req_rdata", req_rdata, 0);
      chk("rst_timeout_err", timeout_err, 0);
    end else begin
      exp_sv = (cyc == m_issue);
      exp_rr = (cyc == m_ready) ? (N'(1) << m_win) : '0;
      chk("s_valid", s_valid, exp_sv);
      chk("s_wstrb", s_wstrb, exp_sv ? m_strb : 4'h0);
      chk("s_address", s_address, m_addr);
      chk("s_wdata", s_wdata, m_wdata);
      chk("req_ready", req_ready, exp_rr);
      if (exp_rr != '0) chk("req_rdata", req_rdata, m_rdata);
      chk("timeout_err", timeout_err, m_err);
      if (s_valid) sv_cyc.push_back(cyc);
      for (int i = 0; i < N; i++)
        if (req_ready[i]) rdy_log.push_back('{idx: i, at: cyc, rdata: req_rdata});
      if (m_wait && cyc > m_issue && s_ready) begin
        m_wait = 0; m_ready = cyc + 1; m_free = cyc + 2; m_rdata = s_rdata;
      end
`ifdef IOB_CLINT_ARB_TIMEOUT_EN
      else if (m_wait && cyc == m_issue + TO) begin
        m_wait = 0; m_ready = cyc + 1; m_free = cyc + 2; m_rdata = 32'hFFFF_FFFF; m_err = 1;
      end
`endif
      if (!m_wait && cyc >= m_free && req_valid != '0) begin
        idx = -1;
        for (int k = 1; k <= N; k++)
          if (idx < 0 && req_valid[(m_ptr + k) % N]) idx = (m_ptr + k) % N;
        m_win = idx; m_ptr = idx; m_issue = cyc + 1; m_wait = 1;
        m_addr  = req_address[idx*AW +: AW];
        m_wdata = req_wdata[idx*DW +: DW];
        m_strb  = req_wstrb[idx*SW +: SW];
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid[i] = v;
    req_address[i*AW +: AW] = a;
    req_wdata[i*DW +: DW]   = d;
    req_wstrb[i*SW +: SW]   = s;
  endtask

  task automatic wait_ready(input int i, input int budget, output int at, output logic [31:0] rd);
    at = -1;
    rd = '0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        at = cyc; rd = req_rdata;
        break;
      end
    end
    chk($sformatf("wait_ready_%0d_in_budget", i), at >= 0, 1);
    tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return iob_clint_arb_pkg::MSIP_BASE;
      1: return 16'h0004;
      2: return iob_clint_arb_pkg::MTIMECMP_BASE;
      3: return 16'h4004;
      4: return iob_clint_arb_pkg::MTIME_BASE;
      default: return 16'hbffc;
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0, at, n0;
    logic [31:0] rd;
    logic [N-1:0] rv;
    bit active [N];
    bit any_active;

    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Single write to mtimecmp[0]
    sv_cyc.delete(); rdy_log.delete();
    t0 = cyc;
    set_req(0, 1'b1, 16'h4000, 32'h5, 4'hF);
    wait_ready(0, 20, at, rd);
    req_valid[0] = 1'b0;
    chk("single_sv_count", sv_cyc.size(), 1);
    chk("single_sv_cycle", sv_cyc[0] - t0, 1);
    chk("single_ready_cycle", at - t0, 3);
    chk("single_mtimecmp", mem[16'h4000], 32'h5);

    // Both requesters held continuously: grants 0,1,0,1 every 4 cycles
    reset_dut();
    rdy_log.delete();
    set_req(0, 1'b1, 16'h0000, 32'h0, 4'h0);
    set_req(1, 1'b1, 16'h0004, 32'h0, 4'h0);
    for (int n = 0; n < 40 && rdy_log.size() < 4; n++) begin
      @(negedge clk); #1;
    end
    tick();
    req_valid = '0;
    chk("rr_count", rdy_log.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_grant_%0d", k), rdy_log[k].idx, k % 2);
    for (int k = 1; k < 4; k++) chk($sformatf("rr_spacing_%0d", k), rdy_log[k].at - rdy_log[k-1].at, 4);

    // mtime write then read back
    set_req(0, 1'b1, 16'hbff8, 32'h10, 4'hF);
    wait_ready(0, 20, at, rd);
    set_req(0, 1'b1, 16'hbff8, 32'hdead_beef, 4'h0);
    wait_ready(0, 20, at, rd);
    req_valid[0] = 1'b0;
    chk("mtime_read", rd, 32'h10);

    // Payload changed after grant; requester 0 withdraws before any grant
    sv_cyc.delete(); rdy_log.delete();
    t0 = cyc;
    set_req(1, 1'b1, 16'h0004, 32'h1, 4'hF);
    tick();
    req_address[1*AW +: AW] = 16'h0008;
    set_req(0, 1'b1, 16'h0000, 32'hdead, 4'hF);
    tick();
    req_valid[0] = 1'b0;
    wait_ready(1, 20, at, rd);
    req_valid[1] = 1'b0;
    repeat (6) tick();
    chk("latched_addr", slave_last_addr, 16'h0004);
    chk("latched_mem", mem[16'h0004], 32'h1);
    chk("changed_addr_untouched", mem.exists(16'h0008), 0);
    chk("withdraw_one_issue", sv_cyc.size(), 1);
    n0 = 0;
    foreach (rdy_log[k]) if (rdy_log[k].idx == 0) n0++;
    chk("withdraw_no_grant", n0, 0);

    // Reset while waiting on the CLINT
    rdy_log.delete();
    slave_stuck = 1'b1;
    set_req(1, 1'b1, 16'h4004, 32'h7, 4'hF);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    req_valid = '0;
    rst = 1'b0;
    slave_stuck = 1'b0;
    repeat (4) tick();
    chk("rst_wait_no_ready", rdy_log.size(), 0);
    chk("rst_wait_addr", s_address, 16'h0);
    t0 = cyc;
    set_req(0, 1'b1, 16'h0000, 32'h0, 4'h0);
    set_req(1, 1'b1, 16'h0004, 32'h0, 4'h0);
    wait_ready(0, 20, at, rd);
    req_valid[0] = 1'b0;
    chk("rst_wait_first_is_0", at - t0, 3);
    wait_ready(1, 20, at, rd);
    req_valid[1] = 1'b0;

`ifdef IOB_CLINT_ARB_TIMEOUT_EN
    slave_stuck = 1'b1;
    t0 = cyc;
    set_req(0, 1'b1, 16'h4000, 32'h9, 4'hF);
    wait_ready(0, TO + 20, at, rd);
    req_valid[0] = 1'b0;
    chk("timeout_ready_cycle", at - t0, TO + 2);
    chk("timeout_rdata", rd, 32'hFFFF_FFFF);
    repeat (5) tick();
    chk("timeout_err_sticky", timeout_err, 1);
    slave_stuck = 1'b0;
    reset_dut();
    chk("timeout_err_cleared", timeout_err, 0);
`endif

    // Randomized traffic against the model
    slave_fixed = 1'b0;
    for (int i = 0; i < N; i++) active[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rv = req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (active[i] && rv[i]) begin
          active[i] = 0;
          req_valid[i] = 1'b0;
        end
        if (!active[i] && $urandom_range(0, 2) == 0) begin
          active[i] = 1;
          set_req(i, 1'b1, rand_addr(), $urandom,
                  ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
        end
      end
    end
    any_active = 1;
    for (int c = 0; c < 200 && any_active; c++) begin
      @(negedge clk);
      rv = req_ready;
      tick();
      any_active = 0;
      for (int i = 0; i < N; i++) begin
        if (active[i] && rv[i]) begin
          active[i] = 0;
          req_valid[i] = 1'b0;
        end
        if (active[i]) any_active = 1;
      end
    end
    chk("random_drained", any_active, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/iob_clint_arbiter.md
# iob_clint_arbiter

Round-robin arbiter that lets N_REQ IOb-native masters (one per core) share the single native slave port of the CLINT. It sits between the core-side interconnect and the CLINT. One transaction is in flight at a time. Each grant's request payload is registered, issued to the CLINT as a one-cycle valid pulse, and its registered rdata is returned to the winner with a one-cycle ready.

## Interface
Parameters:
- ADDR_W, 16, address width (matches CLINT)
- DATA_W, 32, data width (matches CLINT)
- N_REQ, 2, number of requesters, ≥1
- TIMEOUT, 15, cycles waited for s_ready before abort (used only when the timeout feature is compiled in)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester request; held high until the matching req_ready bit
- req_address  in  N_REQ*ADDR_W  requester i uses slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  per-requester write data
- req_wstrb  in  N_REQ*DATA_W/8  per-requester strobes; nonzero means write
- req_rdata  out  DATA_W  shared read data, valid only while a req_ready bit is high
- req_ready  out  N_REQ  one-hot completion pulse, one cycle
- s_valid  out  1  to CLINT valid
- s_address  out  ADDR_W  to CLINT address
- s_wdata  out  DATA_W  to CLINT wdata
- s_wstrb  out  DATA_W/8  to CLINT wstrb
- s_rdata  in  DATA_W  from CLINT rdata
- s_ready  in  1  from CLINT ready
- timeout_err  out  1  sticky flag; set on an aborted transaction

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, the round-robin pick selects the first set bit, searching from ptr+1 modulo N_REQ.
  - Register grant index, address, wdata and wstrb.
  - Set ptr to the grant index. Go to ISSUE.
- ISSUE:
  - s_valid=1 for exactly this cycle, with the registered payload. Go to WAIT.
- WAIT:
  - s_valid=0.
  - On s_ready=1, capture s_rdata into req_rdata. Go to RESP.
- RESP:
  - req_ready[grant]=1 for one cycle. Go to IDLE.
  - No arbitration in RESP, so the completing requester's still-high valid is not re-granted.
- Payload is latched at grant. Requester inputs may change after grant without affecting the transaction.
- A req_valid that drops before grant is ignored. A granted transaction always completes.
- s_address, s_wdata and s_wstrb hold their last value outside ISSUE. s_wstrb is forced to 0 when s_valid=0.
- Write transactions also return the rdata captured from the CLINT; masters ignore it.
- Single requester (N_REQ=1): the pointer is a constant 0 and behaviour is otherwise identical.

## Timing
- Reset values:
  - state=IDLE, ptr=N_REQ-1 (requester 0 wins first).
  - s_valid=0, s_address=0, s_wdata=0, s_wstrb=0.
  - req_ready=0, req_rdata=0, timeout_err=0.
- Latency against the CLINT (ready one cycle after valid):
  - req_valid sampled in IDLE at cycle 0.
  - s_valid at cycle 1.
  - s_ready at cycle 2.
  - req_ready with rdata at cycle 3.
  - IDLE again at cycle 4.
- Throughput: one transaction per 4 cycles under continuous load.
- Fairness: with all requesters asserting continuously, every requester is served once per N_REQ transactions.
- Reset mid-transaction: immediately returns to IDLE and drops the in-flight transaction. No req_ready is issued.

## Configuration
- IOB_CLINT_ARB_TIMEOUT_EN defined:
  - A WAIT-state counter aborts when s_ready has not arrived after TIMEOUT cycles in WAIT.
  - On abort: req_rdata={DATA_W{1'b1}}, go to RESP (req_ready still pulses), set timeout_err.
  - timeout_err clears only on rst.
- Not defined:
  - WAIT waits indefinitely. timeout_err is tied to 0 and TIMEOUT is unused.

## Structure
- Package iob_clint_arb_pkg holds:
  - the state encoding localparams;
  - the CLINT map constants MSIP_BASE=16'h0, MTIMECMP_BASE=16'h4000, MTIME_BASE=16'hbff8, shared with CLINT benches.
- Sub-module iob_rr_picker:
  - combinational round-robin priority search;
  - inputs request vector and ptr; outputs one-hot grant, grant index and any-request flag.

## Test plan
- Single request: req_valid[0] write 32'h5 at 16'h4000.
  - s_valid pulses at cycle 1 and req_ready[0] at cycle 3.
  - CLINT mtimecmp[0][31:0]=32'h5.
- Simultaneous requests: req_valid=2'b11 held continuously, N_REQ=2.
  - Grants alternate 0,1,0,1.
  - Each req_ready is a single cycle, 4 cycles apart.
- Read: read 16'hbff8 after mtime is written to 64'h10.
  - req_rdata=32'h10 in the cycle req_ready[0]=1.
- Payload change and withdrawal:
  - Change requester 1's address after grant: the CLINT still sees the latched address.
  - A requester dropping req_valid before grant gets no grant.
- Reset in WAIT: assert rst in WAIT.
  - All outputs return to their reset values.
  - No req_ready is issued.
  - The next request after reset goes to requester 0.
- With IOB_CLINT_ARB_TIMEOUT_EN and s_ready stuck at 0:
  - req_ready pulses TIMEOUT cycles after WAIT entry with req_rdata=32'hFFFFFFFF.
  - timeout_err=1 and stays set until rst.
